// File: rtl/alu_arbiter_if.sv
// Bundles the signals between alu_arbiter, its requesters and the ALU it drives.
// The slave view belongs to the arbiter. The master view belongs to the environment,
// which is the requesters plus the ALU instance.
interface alu_arbiter_if #(
  parameter int NUM_REQ       = 2,
  parameter int CONTROL_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*CONTROL_WIDTH-1:0] req_ctrl;
  logic [NUM_REQ*5-1:0]             req_shamt;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ-1:0]               rsp_ready;
  logic [DATA_WIDTH-1:0]            rsp_result;
  logic                             rsp_zero;
  logic [CONTROL_WIDTH-1:0]         alu_ctrl;
  logic [4:0]                       alu_shamt;
  logic [DATA_WIDTH-1:0]            alu_a;
  logic [DATA_WIDTH-1:0]            alu_b;
  logic [DATA_WIDTH-1:0]            alu_result;
  logic                             alu_zero;

  modport master (
    output req_valid, req_ctrl, req_shamt, req_a, req_b, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, alu_ctrl, alu_shamt, alu_a, alu_b
  );

  modport slave (
    input  req_valid, req_ctrl, req_shamt, req_a, req_b, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero, alu_ctrl, alu_shamt, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// Each operation is latched, executed for one cycle, and then returned to its
// requester over a valid/ready response channel.
module alu_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int CONTROL_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus,
  output logic           busy
);
  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         grant;
  logic [PTR_W-1:0]         win;
  logic [PTR_W-1:0]         cand;
  logic                     found;
  int                       idx;

  logic [CONTROL_WIDTH-1:0] ctrl_q;
  logic [4:0]               shamt_q;
  logic [DATA_WIDTH-1:0]    a_q;
  logic [DATA_WIDTH-1:0]    b_q;
  logic [DATA_WIDTH-1:0]    result_q;
  logic                     zero_q;

  logic [CONTROL_WIDTH-1:0] ctrl_arr  [NUM_REQ];
  logic [4:0]               shamt_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]    a_arr     [NUM_REQ];
  logic [DATA_WIDTH-1:0]    b_arr     [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ctrl_arr[i]  = bus.req_ctrl[i*CONTROL_WIDTH +: CONTROL_WIDTH];
    assign shamt_arr[i] = bus.req_shamt[i*5 +: 5];
    assign a_arr[i]     = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[i]     = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or above rr_ptr, wrapping back to requester 0
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Accept strobe: only the winner, only while idle
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found) bus.req_ready[win] = 1'b1;
  end

  // Response strobe: one-hot toward the granted requester while responding
  always_comb begin
    bus.rsp_valid = '0;
    if (state == RESP) bus.rsp_valid[grant] = 1'b1;
  end

  assign bus.alu_ctrl   = ctrl_q;
  assign bus.alu_shamt  = shamt_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign busy           = (state != IDLE);

  // Sequencer: accept -> execute -> respond. rr_ptr moves only when a response completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      ctrl_q   <= '0;
      shamt_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= win;
            ctrl_q  <= ctrl_arr[win];
            shamt_q <= shamt_arr[win];
            a_q     <= a_arr[win];
            b_q     <= b_arr[win];
            state   <= EXEC;
          end
        end
        EXEC: begin
          result_q <= bus.alu_result;
          zero_q   <= bus.alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[grant]) begin
            rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + PTR_W'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
